// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3x3 tap array.
// Emits interior windows only, two clocks after the completing pixel.
//
// Ports:
//   clock, reset      single clock, asynchronous active-high reset
//   din, valid        pixel stream from the upsampler (gaps allowed)
//   rownum, colnum    position of din (checked only with FRAME_CHECK_EN)
//   win               9 taps, tap k=3*i+j at win[k*DW +: DW]
//   win_valid         one-cycle strobe qualifying win/ctr_row/ctr_col
//   ctr_row, ctr_col  position of the centre tap
//   frame_done        one-cycle strobe after the last pixel of a frame
//   sync_err          sticky position-mismatch flag
//
// Optional feature macro: FRAME_CHECK_EN (position check against
// rownum/colnum while running; sync_err tied 0 when undefined).
module window3x3_gen #(
  parameter int DW    = 8,
  parameter int IMG_W = 800,
  parameter int IMG_H = 600
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [DW-1:0]   din,
  input  logic            valid,
  input  logic [9:0]      rownum,
  input  logic [9:0]      colnum,
  output logic [9*DW-1:0] win,
  output logic            win_valid,
  output logic [9:0]      ctr_row,
  output logic [9:0]      ctr_col,
  output logic            frame_done,
  output logic            sync_err
);

  localparam int AW = $clog2(IMG_W);
  localparam logic [9:0] LAST_C = 10'(IMG_W - 1);
  localparam logic [9:0] LAST_R = 10'(IMG_H - 1);

  typedef enum logic {
    S_WAIT_SOF,
    S_RUN
  } state_t;

  state_t r_state;
  logic [9:0] r_row;
  logic [9:0] r_col;
  logic       r_frame_done;

  // Line buffer entry: [2DW-1:DW] two rows up, [DW-1:0] one row up.
  logic [2*DW-1:0] r_lb [IMG_W];
  logic [2*DW-1:0] r_rd;

  // Stage 1: accepted pixel and its position.
  logic          r_v1;
  logic [9:0]    r_r1;
  logic [9:0]    r_c1;
  logic [DW-1:0] r_din1;

  // Stage 2: tap array and output registers.
  logic [DW-1:0]   r_arr [3][3];
  logic [9*DW-1:0] r_win;
  logic            r_win_valid;
  logic [9:0]      r_ctr_row;
  logic [9:0]      r_ctr_col;

  logic          w_sof;
  logic          w_mis;
  logic          w_acc;
  logic          w_last;
  logic [9:0]    w_pr;
  logic [9:0]    w_pc;
  logic [DW-1:0] w_col [3];
  logic [DW-1:0] w_nxt [3][3];
  logic [9*DW-1:0] w_win;

  always_comb begin
    w_sof = valid && (rownum == 10'd0) && (colnum == 10'd0);
`ifdef FRAME_CHECK_EN
    w_mis = (r_state == S_RUN) && valid &&
            ((rownum != r_row) || (colnum != r_col));
`else
    w_mis = 1'b0;
`endif
    w_acc = 1'b0;
    w_pr  = r_row;
    w_pc  = r_col;
    // A mismatching pixel is re-evaluated as a possible start of frame.
    if ((r_state == S_RUN) && !w_mis) begin
      w_acc = valid;
    end else if (w_sof) begin
      w_acc = 1'b1;
      w_pr  = 10'd0;
      w_pc  = 10'd0;
    end
    w_last = (w_pr == LAST_R) && (w_pc == LAST_C);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT_SOF;
      r_row        <= 10'd0;
      r_col        <= 10'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_last;
      if (w_acc) begin
        if (w_last) begin
          r_state <= S_WAIT_SOF;
          r_row   <= 10'd0;
          r_col   <= 10'd0;
        end else begin
          r_state <= S_RUN;
          if (w_pc == LAST_C) begin
            r_row <= w_pr + 10'd1;
            r_col <= 10'd0;
          end else begin
            r_row <= w_pr;
            r_col <= w_pc + 10'd1;
          end
        end
      end else if (w_mis) begin
        r_state <= S_WAIT_SOF;
        r_row   <= 10'd0;
        r_col   <= 10'd0;
      end
    end
  end

`ifdef FRAME_CHECK_EN
  logic r_sync_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_err <= 1'b0;
    end else if (w_mis) begin
      r_sync_err <= 1'b1;
    end
  end

  assign sync_err = r_sync_err;
`else
  assign sync_err = 1'b0;
`endif

  // Read in stage 1, write back in stage 2: the column being read is
  // never the one being written, so the shifted entry uses old data.
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_rd <= r_lb[w_pc[AW-1:0]];
    end
    if (r_v1) begin
      r_lb[r_c1[AW-1:0]] <= {r_rd[DW-1:0], r_din1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_r1   <= 10'd0;
      r_c1   <= 10'd0;
      r_din1 <= '0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_r1   <= w_pr;
        r_c1   <= w_pc;
        r_din1 <= din;
      end
    end
  end

  always_comb begin
    w_col[0] = r_rd[2*DW-1:DW];
    w_col[1] = r_rd[DW-1:0];
    w_col[2] = r_din1;
    w_win    = '0;
    for (int i = 0; i < 3; i++) begin
      w_nxt[i][0] = r_arr[i][1];
      w_nxt[i][1] = r_arr[i][2];
      w_nxt[i][2] = w_col[i];
      for (int j = 0; j < 3; j++) begin
        w_win[(3*i+j)*DW +: DW] = w_nxt[i][j];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_arr[i][j] <= '0;
        end
      end
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_ctr_row   <= 10'd0;
      r_ctr_col   <= 10'd0;
    end else begin
      r_win_valid <= 1'b0;
      if (r_v1) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            r_arr[i][j] <= w_nxt[i][j];
          end
        end
        // Columns 0/1 of a row only refill the array.
        if ((r_r1 >= 10'd2) && (r_c1 >= 10'd2)) begin
          r_win       <= w_win;
          r_win_valid <= 1'b1;
          r_ctr_row   <= r_r1 - 10'd1;
          r_ctr_col   <= r_c1 - 10'd1;
        end
      end
    end
  end

  assign win        = r_win;
  assign win_valid  = r_win_valid;
  assign ctr_row    = r_ctr_row;
  assign ctr_col    = r_ctr_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: image-level model of accepted pixels,
// expected-window queue with due cycles, directed frame scenarios.
module tb_window3x3_gen;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          valid;
  logic [9:0]    rownum;
  logic [9:0]    colnum;
  logic [9*DW-1:0] win;
  logic          win_valid;
  logic [9:0]    ctr_row;
  logic [9:0]    ctr_col;
  logic          frame_done;
  logic          sync_err;

  window3x3_gen #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .reset(reset), .din(din), .valid(valid),
    .rownum(rownum), .colnum(colnum), .win(win),
    .win_valid(win_valid), .ctr_row(ctr_row), .ctr_col(ctr_col),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clock = ~clock;

  int ncyc = 0;
  always @(posedge clock) ncyc <= ncyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int         due;
    logic [9:0] r;
    logic [9:0] c;
    logic [71:0] w;
  } exp_t;

  exp_t q_win[$];
  int   q_fd[$];

  logic [7:0] img [H][W];
  bit   m_run;
  int   m_r;
  int   m_c;
  bit   m_err;

  logic [71:0] m_last_win;
  logic [9:0]  m_last_r;
  logic [9:0]  m_last_c;

  int          n_win;
  int          n_fd;
  bit          got_first;
  logic [71:0] first_win;
  int          first_cyc;
  logic [71:0] w11;

  task automatic chk(input string name, input logic [95:0] act,
                     input logic [95:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model: where does an accepted pixel land, what
  // window does that complete and when is it due.
  task automatic model_pix(input int r, input int c, input logic [7:0] d);
    bit acc = 0;
    bit mis = 0;
    int pr = m_r;
    int pc = m_c;
    exp_t e;
`ifdef FRAME_CHECK_EN
    if (m_run && (r != m_r || c != m_c)) mis = 1;
`endif
    if (m_run && !mis) acc = 1;
    else if (r == 0 && c == 0) begin
      acc = 1; pr = 0; pc = 0;
    end
    if (mis) begin
      m_err = 1; m_run = 0;
    end
    if (acc) begin
      img[pr][pc] = d;
      if (pr >= 2 && pc >= 2) begin
        e.due = ncyc + 2;
        e.r = 10'(pr - 1);
        e.c = 10'(pc - 1);
        e.w = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[(3*i+j)*8 +: 8] = img[pr-2+i][pc-2+j];
        q_win.push_back(e);
      end
      if (pr == H-1 && pc == W-1) begin
        q_fd.push_back(ncyc + 1);
        m_run = 0; m_r = 0; m_c = 0;
      end else begin
        m_run = 1;
        m_r = pr;
        m_c = pc + 1;
        if (m_c == W) begin
          m_c = 0; m_r = pr + 1;
        end
      end
    end
  endtask

  task automatic drive(input int r, input int c, input logic [7:0] d);
    valid  = 1'b1;
    rownum = 10'(r);
    colnum = 10'(c);
    din    = d;
    model_pix(r, c, d);
    @(posedge clock);
    #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] off, input int duty,
                            input int npix, input int skip);
    for (int k = 0; k < npix; k++) begin
      if (k != skip) begin
        while ($urandom_range(0, 99) >= duty) idle(1);
        drive(k / W, k % W, 8'(16 * (k / W) + (k % W)) + off);
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    q_win.delete();
    q_fd.delete();
    m_run = 0; m_r = 0; m_c = 0; m_err = 0;
    m_last_win = '0; m_last_r = '0; m_last_c = '0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      chk("reset_outputs",
          {win, win_valid, ctr_row, ctr_col, frame_done, sync_err}, '0);
    end else begin
      if (win_valid) begin
        if (q_win.size() == 0) begin
          chk("unexpected_win", {ctr_row, ctr_col}, '1);
        end else begin
          e = q_win.pop_front();
          chk("win_latency", 96'(ncyc), 96'(e.due));
          chk("win_taps", {24'd0, win}, {24'd0, e.w});
          chk("ctr_pos", {ctr_row, ctr_col}, {e.r, e.c});
          m_last_win = e.w; m_last_r = e.r; m_last_c = e.c;
          n_win++;
          if (!got_first) begin
            got_first = 1; first_win = win; first_cyc = ncyc;
          end
          if (e.r == 10'd1 && e.c == 10'd1) w11 = win;
        end
      end else begin
        chk("win_hold", {ctr_row, ctr_col, win},
            {m_last_r, m_last_c, m_last_win});
        if (q_win.size() > 0 && q_win[0].due <= ncyc) begin
          e = q_win.pop_front();
          chk("missing_win", {1'b0, e.r, e.c}, {1'b1, e.r, e.c});
        end
      end
      if (frame_done) begin
        n_fd++;
        if (q_fd.size() == 0) chk("unexpected_fd", 96'd1, 96'd0);
        else chk("fd_latency", 96'(ncyc), 96'(q_fd.pop_front()));
      end else if (q_fd.size() > 0 && q_fd[0] <= ncyc) begin
        chk("missing_fd", 96'(q_fd.pop_front()), 96'd0);
      end
    end
  end

  int w0;
  int f0;
  int c0;

  initial begin
    reset = 1'b1; valid = 1'b0; din = '0; rownum = '0; colnum = '0;
    m_run = 0; m_r = 0; m_c = 0; m_err = 0;
    m_last_win = '0; m_last_r = '0; m_last_c = '0;
    n_win = 0; n_fd = 0; got_first = 0; w11 = '0;
    first_win = '0; first_cyc = 0;
    do_reset(3);
    chk("sync_err_reset", 96'(sync_err), 96'd0);

    // 1: full frame, valid every cycle
    w0 = n_win; f0 = n_fd; got_first = 0; c0 = ncyc;
    send_frame(8'h00, 100, W*H, -1);
    idle(4);
    chk("t1_count", 96'(n_win - w0), 96'd24);
    chk("t1_fd", 96'(n_fd - f0), 96'd1);
    chk("t1_first", {24'd0, first_win}, {24'd0, 72'h222120121110020100});
    chk("t1_first_cyc", 96'(first_cyc), 96'(c0 + 20));

    // 2: 30% duty
    w0 = n_win; f0 = n_fd; got_first = 0;
    send_frame(8'h00, 30, W*H, -1);
    idle(4);
    chk("t2_count", 96'(n_win - w0), 96'd24);
    chk("t2_fd", 96'(n_fd - f0), 96'd1);
    chk("t2_first", {24'd0, first_win}, {24'd0, 72'h222120121110020100});

    // 3: mid-frame pixels before a start of frame
    w0 = n_win; f0 = n_fd;
    for (int k = 3*W + 5; k < W*H; k++) drive(k / W, k % W, 8'hEE);
    idle(4);
    chk("t3_pre_sof", 96'(n_win - w0 + n_fd - f0), 96'd0);
    w0 = n_win; got_first = 0;
    send_frame(8'h00, 100, W*H, -1);
    idle(4);
    chk("t3_count", 96'(n_win - w0), 96'd24);
    chk("t3_first", {24'd0, first_win}, {24'd0, 72'h222120121110020100});

    // 4: reset at pixel (3,4), then a fresh frame
    send_frame(8'h40, 100, 3*W + 5, -1);
    do_reset(2);
    w0 = n_win; f0 = n_fd; got_first = 0;
    send_frame(8'h00, 100, W*H, -1);
    idle(4);
    chk("t4_count", 96'(n_win - w0), 96'd24);
    chk("t4_fd", 96'(n_fd - f0), 96'd1);
    chk("t4_first", {24'd0, first_win}, {24'd0, 72'h222120121110020100});

    // 5: two frames back to back
    w0 = n_win; f0 = n_fd;
    send_frame(8'h00, 100, W*H, -1);
    send_frame(8'h80, 100, W*H, -1);
    idle(4);
    chk("t5_count", 96'(n_win - w0), 96'd48);
    chk("t5_fd", 96'(n_fd - f0), 96'd2);
    chk("t5_win11", {24'd0, w11}, {24'd0, 72'hA2A1A0929190828180});

    // 6: pixel (2,3) skipped
    w0 = n_win;
    send_frame(8'h00, 100, W*H, 2*W + 3);
    idle(4);
`ifdef FRAME_CHECK_EN
    chk("t6_sync_err", 96'(sync_err), 96'd1);
    chk("t6_count", 96'(n_win - w0), 96'd1);
    drive(4, 0, 8'h40);
    idle(3);
    chk("t6_sticky", 96'(sync_err), 96'd1);
`else
    chk("t6_sync_err", 96'(sync_err), 96'd0);
    chk("t6_count", 96'(n_win - w0), 96'd23);
`endif
    chk("t6_model_err", 96'(sync_err), 96'(m_err));
    do_reset(2);
    chk("t6_cleared", 96'(sync_err), 96'd0);

    idle(4);
    chk("drain_win", 96'(q_win.size()), 96'd0);
    chk("drain_fd", 96'(q_fd.size()), 96'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
